// File: rtl/varredura_hexa_if.sv
`default_nettype none
// ============================================================================
//  Module      : varredura_hexa_if
//  Description : Value/strobe inputs and scan outputs of the hex display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface varredura_hexa_if #(
    parameter int DIGITOS = 4
) ();
    logic [4*DIGITOS-1:0]         valor;
    logic                         carrega;
    logic                         apaga_zeros;
    logic [3:0]                   nibble;
    logic [DIGITOS-1:0]           anodo;
    logic [$clog2(DIGITOS)-1:0]   digito;
    logic                         quadro;

    modport master (
        output valor, carrega, apaga_zeros,
        input  nibble, anodo, digito, quadro
    );

    modport slave (
        input  valor, carrega, apaga_zeros,
        output nibble, anodo, digito, quadro
    );
endinterface
`default_nettype wire

// File: rtl/varredura_hexa.sv
`default_nettype none
// ============================================================================
//  Module      : varredura_hexa
//  Description : Multiplexed scan driver for a common-anode 7-segment display
//                with slot blanking, leading-zero suppression and frame-aligned
//                value update.
//  Revision    : 1.0 - initial release
// ============================================================================
module varredura_hexa #(
    parameter int DIGITOS    = 4,
    parameter int DIV        = 50000,
    parameter int APAGAMENTO = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    varredura_hexa_if.slave    bus
);

    localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_IW = $clog2(DIGITOS);

    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0] c_APAG    = c_CW'(APAGAMENTO);
    localparam logic [c_IW-1:0] c_IDX_MAX = c_IW'(DIGITOS - 1);

    logic [c_CW-1:0]        r_cnt;
    logic [c_IW-1:0]        r_idx;
    logic [4*DIGITOS-1:0]   r_exib;
    logic [4*DIGITOS-1:0]   r_reserva;
    logic                   r_pend;

    logic [3:0]             r_nibble;
    logic [DIGITOS-1:0]     r_anodo;
    logic [c_IW-1:0]        r_digito;
    logic                   r_quadro;

    logic                   w_tick;
    logic                   w_fronteira;
    logic [DIGITOS-1:0]     w_zero_from;
    logic [3:0]             w_nibble;
    logic [DIGITOS-1:0]     w_anodo;

    assign w_tick      = (r_cnt == c_CNT_MAX);
    assign w_fronteira = w_tick && (r_idx == c_IDX_MAX);

    // w_zero_from[g]: every nibble from digit g up to the most significant is zero
    genvar g;
    generate
        for (g = 0; g < DIGITOS; g++) begin : g_zero_from
            assign w_zero_from[g] = (r_exib[4*DIGITOS-1:4*g] == '0);
        end
    endgenerate

    // Decoding by loop keeps an out-of-range index harmless: nothing matches
    always_comb begin
        w_nibble = '0;
        w_anodo  = '1;
        for (int i = 0; i < DIGITOS; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_nibble = r_exib[4*i +: 4];
                if ((r_cnt >= c_APAG) &&
                    !(bus.apaga_zeros && (i > 0) && w_zero_from[i])) begin
                    w_anodo[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_exib    <= '0;
            r_reserva <= '0;
            r_pend    <= 1'b0;
            r_nibble  <= '0;
            r_anodo   <= '1;
            r_digito  <= '0;
            r_quadro  <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + c_CW'(1);

            if (w_tick) begin
                r_idx <= (r_idx >= c_IDX_MAX) ? '0 : r_idx + c_IW'(1);
            end

            if (bus.carrega) begin
                r_reserva <= bus.valor;
            end

            // The displayed value only moves at a frame edge, so a frame never mixes two values
            if (w_fronteira) begin
                r_pend <= 1'b0;
                if (bus.carrega) begin
                    r_exib <= bus.valor;
                end else if (r_pend) begin
                    r_exib <= r_reserva;
                end
            end else if (bus.carrega) begin
                r_pend <= 1'b1;
            end

            r_nibble <= w_nibble;
            r_anodo  <= w_anodo;
            r_digito <= r_idx;
            r_quadro <= w_fronteira;
        end
    end

    assign bus.nibble = r_nibble;
    assign bus.anodo  = r_anodo;
    assign bus.digito = r_digito;
    assign bus.quadro = r_quadro;

endmodule
`default_nettype wire

// File: tb/tb_varredura_hexa.sv
`default_nettype none
// ============================================================================
//  Module      : tb_varredura_hexa
//  Description : Directed self-checking bench for varredura_hexa (4 digits,
//                4-cycle slots, 1 blank cycle -> 16-cycle frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_varredura_hexa;

    localparam int c_DIGITOS = 4;
    localparam int c_DIV     = 4;
    localparam int c_APAG    = 1;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    int frame;
    int sample;

    varredura_hexa_if #(.DIGITOS(c_DIGITOS)) vh_if ();

    varredura_hexa #(
        .DIGITOS    (c_DIGITOS),
        .DIV        (c_DIV),
        .APAGAMENTO (c_APAG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vh_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (frame %0d sample %0d): got %0h, expected %0h",
                     tag, frame, sample, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_anodo",  32'(vh_if.anodo),  32'hF);
        check("rst_nibble", 32'(vh_if.nibble), 32'h0);
        check("rst_digito", 32'(vh_if.digito), 32'h0);
        check("rst_quadro", 32'(vh_if.quadro), 32'h0);
    endtask

    task automatic wait_quadro();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (vh_if.quadro) seen = 1'b1;
        end
        check("quadro_timeout", 32'(seen), 32'h1);
    endtask

    // Checks one full frame starting right after the sample where quadro was seen.
    // Loads of va/vb are strobed at samples la/lb (0 = none).
    task automatic check_frame(input logic [15:0] v, input logic az,
                               input int la, input logic [15:0] va,
                               input int lb, input logic [15:0] vb);
        logic [3:0] exp_an;
        int c;
        int i;
        frame++;
        vh_if.apaga_zeros = az;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            sample = j;
            c = (j - 1) % 4;
            i = (j - 1) / 4;
            exp_an = 4'b1111;
            if ((c >= c_APAG) && !(az && (i > 0) && ((v >> (4*i)) == 16'h0)))
                exp_an[i] = 1'b0;
            check("nibble", 32'(vh_if.nibble), 32'((v >> (4*i)) & 16'hF));
            check("anodo",  32'(vh_if.anodo),  32'(exp_an));
            check("digito", 32'(vh_if.digito), 32'(i));
            check("quadro", 32'(vh_if.quadro), 32'(j == 16));
            if (j == la) begin
                vh_if.valor   = va;
                vh_if.carrega = 1'b1;
            end else if (j == lb) begin
                vh_if.valor   = vb;
                vh_if.carrega = 1'b1;
            end else begin
                vh_if.carrega = 1'b0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        frame    = 0;
        sample   = 0;
        rst               = 1'b1;
        vh_if.valor       = '0;
        vh_if.carrega     = 1'b0;
        vh_if.apaga_zeros = 1'b0;

        // Reset held for three cycles, then one more cycle of reset values
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        check("first_anodo",  32'(vh_if.anodo),  32'hE);
        check("first_nibble", 32'(vh_if.nibble), 32'h0);

        vh_if.valor   = 16'hA5C3;
        vh_if.carrega = 1'b1;
        @(negedge clk);
        vh_if.carrega = 1'b0;
        wait_quadro();

        // Scan order and quadro period
        check_frame(16'hA5C3, 1'b0, 0, 16'h0, 0, 16'h0);
        // Two loads inside one frame: frame unchanged, last one wins
        check_frame(16'hA5C3, 1'b0, 4, 16'h1111, 8, 16'h2222);
        check_frame(16'h2222, 1'b0, 10, 16'h0005, 0, 16'h0);
        // Leading-zero suppression
        check_frame(16'h0005, 1'b1, 3, 16'h0000, 0, 16'h0);
        check_frame(16'h0000, 1'b1, 5, 16'h0005, 0, 16'h0);
        // Suppression off, load exactly in the boundary cycle
        check_frame(16'h0005, 1'b0, 15, 16'h7E01, 0, 16'h0);
        check_frame(16'h7E01, 1'b0, 0, 16'h0, 0, 16'h0);
        check_frame(16'h7E01, 1'b0, 0, 16'h0, 0, 16'h0);

        // Mid-frame reset with a load pending, pulsed while idx == 2
        frame++;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            sample = j;
            if (j == 1) begin
                vh_if.valor   = 16'hBEEF;
                vh_if.carrega = 1'b1;
            end else begin
                vh_if.carrega = 1'b0;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        sample = 10;
        check_reset_outputs();
        rst = 1'b0;
        check_frame(16'h0000, 1'b0, 0, 16'h0, 0, 16'h0);
        check_frame(16'h0000, 1'b0, 0, 16'h0, 0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
